edit_mode_controller: RTL

EDIT_MODE_CONTROLLER -- requirements
Module: edit_mode_controller

---
 rtl/edit_mode_controller.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/edit_mode_controller.sv
// Edit-mode key controller for a clock/calendar display.
// Keys are synchronised and debounced; presses drive a VIEW/EDIT FSM.
// Ports:
//   clk, reset                     : clock, async active-high reset
//   KeyMode/KeyEdit/KeyPlus/KeyMinus : active-low raw keys
//   screen[1:0], EditMode, position[1:0] : display/edit state
//   IncPulse, DecPulse             : one-cycle field adjust strobes
module edit_mode_controller #(
    parameter int DB_CYCLES      = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int REPEAT_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       KeyMode,
    input  logic       KeyEdit,
    input  logic       KeyPlus,
    input  logic       KeyMinus,
    output logic [1:0] screen,
    output logic       EditMode,
    output logic [1:0] position,
    output logic       IncPulse,
    output logic       DecPulse
);

    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    // key index: 0 mode, 1 edit, 2 plus, 3 minus
    localparam int K_MODE  = 0;
    localparam int K_EDIT  = 1;
    localparam int K_PLUS  = 2;
    localparam int K_MINUS = 3;

    typedef enum logic {VIEW, EDIT} state_t;

    logic [3:0]          raw;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          db_q, db_d, dbp_q;
    logic [3:0][DBW-1:0] dbc_q, dbc_d;
    logic [3:0]          press;

    state_t        state_q, state_d;
    logic [1:0]    scr_q, scr_d;
    logic [1:0]    pos_q, pos_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic [TW-1:0] to_q, to_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          arm_q, arm_d;
    logic          dir_q, dir_d;

    logic          plus_lo, minus_lo, both_lo, one_lo;
    logic          leave;
    logic [1:0]    last_pos;

    assign raw = {KeyMinus, KeyPlus, KeyEdit, KeyMode};

    // Level flips only after DB_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_d[i]  = db_q[i];
            dbc_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dbc_q[i] == DBW'(DB_CYCLES - 1))
                    db_d[i] = sync2_q[i];
                else
                    dbc_d[i] = dbc_q[i] + DBW'(1);
            end
        end
    end

    assign press    = dbp_q & ~db_q;
    assign plus_lo  = ~db_q[K_PLUS];
    assign minus_lo = ~db_q[K_MINUS];
    assign both_lo  = plus_lo & minus_lo;
    assign one_lo   = plus_lo ^ minus_lo;

    always_comb begin
        last_pos = 2'd0;
        case (scr_q)
            2'd0:    last_pos = 2'd2;
            2'd1:    last_pos = 2'd2;
            2'd2:    last_pos = 2'd1;
            default: last_pos = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        scr_d   = scr_q;
        pos_d   = pos_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        to_d    = to_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        arm_d   = arm_q;
        dir_d   = dir_q;
        leave   = 1'b0;

        unique case (state_q)
            VIEW: begin
                arm_d  = 1'b0;
                hold_d = '0;
                rep_d  = 1'b0;
                to_d   = '0;
                if (press[K_EDIT]) begin
                    state_d = EDIT;
                    pos_d   = 2'd0;
                end else if (press[K_MODE]) begin
                    scr_d = scr_q + 2'd1;
                    pos_d = 2'd0;
                end
            end
            EDIT: begin
                to_d = to_q + TW'(1);
                if (press[K_EDIT]) begin
                    leave = 1'b1;
                end else if (press[K_MODE]) begin
                    pos_d = (pos_q >= last_pos) ? 2'd0 : pos_q + 2'd1;
                    to_d  = '0;
                    if (both_lo) begin
                        arm_d  = 1'b0;
                        hold_d = '0;
                        rep_d  = 1'b0;
                    end
                end else if (both_lo) begin
                    arm_d  = 1'b0;
                    hold_d = '0;
                    rep_d  = 1'b0;
                    to_d   = '0;
                end else if (press[K_PLUS] || press[K_MINUS]) begin
                    // only one can be set here: both_lo was excluded
                    inc_d  = press[K_PLUS];
                    dec_d  = press[K_MINUS];
                    arm_d  = 1'b1;
                    dir_d  = press[K_PLUS];
                    hold_d = '0;
                    rep_d  = 1'b0;
                    to_d   = '0;
                end else if (arm_q && (dir_q ? plus_lo : minus_lo)) begin
                    to_d = '0;
                    if (!rep_q) begin
                        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                            inc_d  = dir_q;
                            dec_d  = ~dir_q;
                            hold_d = '0;
                            rep_d  = 1'b1;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end else if (hold_q == HW'(REPEAT_CYCLES - 1)) begin
                        inc_d  = dir_q;
                        dec_d  = ~dir_q;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    // a key left low after its partner was released
                    // stays disarmed until pressed again
                    arm_d  = 1'b0;
                    hold_d = '0;
                    rep_d  = 1'b0;
                    if (one_lo)
                        to_d = '0;
                    else if (to_q == TW'(TIMEOUT_CYCLES - 1))
                        leave = 1'b1;
                end
            end
        endcase

        if (leave) begin
            state_d = VIEW;
            pos_d   = 2'd0;
            inc_d   = 1'b0;
            dec_d   = 1'b0;
            to_d    = '0;
            hold_d  = '0;
            rep_d   = 1'b0;
            arm_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            dbp_q   <= '1;
            dbc_q   <= '0;
            state_q <= VIEW;
            scr_q   <= 2'd0;
            pos_q   <= 2'd0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            to_q    <= '0;
            hold_q  <= '0;
            rep_q   <= 1'b0;
            arm_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dbp_q   <= db_q;
            dbc_q   <= dbc_d;
            state_q <= state_d;
            scr_q   <= scr_d;
            pos_q   <= pos_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            to_q    <= to_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            arm_q   <= arm_d;
            dir_q   <= dir_d;
        end
    end

    assign screen   = scr_q;
    assign EditMode = (state_q == EDIT);
    assign position = pos_q;
    assign IncPulse = inc_q;
    assign DecPulse = dec_q;

endmodule
